// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: bundles both requester ports, the completion/status outputs
// and the single-port RAM side of the arbiter.
// slave  = arbiter side, master = requesters + RAM side.
interface ram_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [7:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        ld_req;
    logic        ld_we;
    logic [7:0]  ld_addr;
    logic [15:0] ld_wdata;
    logic        cpu_ack;
    logic        ld_ack;
    logic [15:0] rdata;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic        busy;
    logic        grant_ld;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        input  ram_dout,
        output cpu_ack, ld_ack, rdata,
        output ram_we, ram_addr, ram_din,
        output busy, grant_ld
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ld_req, ld_we, ld_addr, ld_wdata,
        output ram_dout,
        input  cpu_ack, ld_ack, rdata,
        input  ram_we, ram_addr, ram_din,
        input  busy, grant_ld
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: two-port (CPU, loader) arbiter in front of a synchronous
// single-port RAM with 1-cycle read latency. Each access walks
// IDLE -> ACCESS -> CAPTURE -> DONE, so one access completes every 4 cycles.
// Optional macro ARB_RR_EN: round-robin tie-break instead of fixed CPU priority.
module ram_arbiter (
    input  logic          clk,
    input  logic          rst_n,
    ram_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic        ram_we_q, ram_we_d;
    logic [7:0]  ram_addr_q, ram_addr_d;
    logic [15:0] ram_din_q, ram_din_d;
    logic [15:0] rdata_q, rdata_d;
    logic        cpu_ack_q, cpu_ack_d;
    logic        ld_ack_q, ld_ack_d;
    logic        grant_ld_q, grant_ld_d;
    // Write flag of the granted access; ram_we itself drops after ACCESS.
    logic        wr_q, wr_d;
    logic        pick_ld;

`ifdef ARB_RR_EN
    // 1 = loader wins the next tie (it was not granted last); resets to CPU.
    logic        prio_ld_q, prio_ld_d;

    // Round-robin winner select: on a tie, the port not granted last wins
    always_comb pick_ld = bus.ld_req && (!bus.cpu_req || prio_ld_q);

    // Track which port gets the next tie
    always_comb begin
        prio_ld_d = prio_ld_q;
        if (state_q == IDLE && (bus.cpu_req || bus.ld_req))
            prio_ld_d = !pick_ld;
    end

    // Round-robin priority register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prio_ld_q <= 1'b0;
        else        prio_ld_q <= prio_ld_d;
    end
`else
    // Fixed-priority winner select: CPU beats loader
    always_comb pick_ld = bus.ld_req && !bus.cpu_req;
`endif

    // Next-state and registered-output logic of the access sequencer
    always_comb begin
        state_d    = state_q;
        ram_we_d   = ram_we_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        rdata_d    = rdata_q;
        cpu_ack_d  = 1'b0;
        ld_ack_d   = 1'b0;
        grant_ld_d = grant_ld_q;
        wr_d       = wr_q;
        case (state_q)
            IDLE: begin
                if (bus.cpu_req || bus.ld_req) begin
                    grant_ld_d = pick_ld;
                    ram_addr_d = pick_ld ? bus.ld_addr  : bus.cpu_addr;
                    ram_din_d  = pick_ld ? bus.ld_wdata : bus.cpu_wdata;
                    ram_we_d   = pick_ld ? bus.ld_we    : bus.cpu_we;
                    wr_d       = pick_ld ? bus.ld_we    : bus.cpu_we;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                // RAM samples addr/we at the end of this cycle
                ram_we_d = 1'b0;
                state_d  = CAPTURE;
            end
            CAPTURE: begin
                if (!wr_q) rdata_d = bus.ram_dout;
                cpu_ack_d = !grant_ld_q;
                ld_ack_d  = grant_ld_q;
                state_d   = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset clears everything including ram_we
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ram_we_q   <= 1'b0;
            ram_addr_q <= 8'h00;
            ram_din_q  <= 16'h0000;
            rdata_q    <= 16'h0000;
            cpu_ack_q  <= 1'b0;
            ld_ack_q   <= 1'b0;
            grant_ld_q <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            rdata_q    <= rdata_d;
            cpu_ack_q  <= cpu_ack_d;
            ld_ack_q   <= ld_ack_d;
            grant_ld_q <= grant_ld_d;
            wr_q       <= wr_d;
        end
    end

    assign bus.ram_we   = ram_we_q;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_din  = ram_din_q;
    assign bus.rdata    = rdata_q;
    assign bus.cpu_ack  = cpu_ack_q;
    assign bus.ld_ack   = ld_ack_q;
    assign bus.grant_ld = grant_ld_q;
    assign bus.busy     = (state_q != IDLE);

endmodule
